transmissor_status: RTL
=======================

Name: transmissor_status

Overview:
- Downstream stage of the Polilock top level. Watches the controller outcome outputs (acertou, errou, bloqueado) and reports each new event to the host as one UART byte on a tx line.
- Rising-edge event detection, a pending/arbitration stage, a small event FIFO and a UART transmitter FSM.
- Serial framing parameters match the receive side so host link settings are symmetric.

Parameters:
- BAUD_RATE, 9600, serial bit rate.
- CLOCK_HZ, 50_000_000, system clock frequency; CLKS_PER_BIT = CLOCK_HZ/BAUD_RATE, integer division, truncated.
- STOP_BITS, 1, number of stop bits (1 or 2).
- N_BITS, 8, data bits per frame.
- FIFO_DEPTH, 4, event FIFO entries (power of 2).
- CODE_ACERTOU, 8'h41, byte sent on an acertou event.
- CODE_ERROU, 8'h45, byte sent on an errou event.
- CODE_BLOQUEADO, 8'h42, byte sent on a bloqueado event.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = new frames may start.
- acertou  in  1  controller success level.
- errou  in  1  controller failure level.
- bloqueado  in  1  lockout level (db_bloqueado).
- tx  out  1  serial line, idle high.
- busy  out  1  1 while a frame is in progress (state != OCIOSO).
- fifo_cheia  out  1  FIFO holds FIFO_DEPTH entries.
- descartados  out  4  count of merged/lost events, saturates at 15.
- db_estado  out  3  FSM code: OCIOSO=0, START=1, DADOS=2, STOP=3.

Behaviour:
- Only clock is used. Reset is sampled on a clock edge when reset=0.
- Reset values:
  - tx=1, busy=0, fifo_cheia=0, descartados=0, db_estado=0.
  - FIFO emptied, pending bits cleared, bit/baud counters 0.
  - Edge-detect registers load the current input levels during reset, so levels held across reset generate no event.
- Reset mid-frame aborts the frame: tx=1 after that edge, and nothing further is sent.
- Event detection: registered previous value per input. An event occurs when input=1 and prev=0 at edge k, and sets that input's pending bit at edge k. A level held high yields exactly one event.
- Arbitration: each cycle, if the FIFO is not full, the highest-priority pending bit is written to the FIFO and cleared. Priority order is acertou > errou > bloqueado.
  - Simultaneous events therefore enqueue on consecutive cycles in that order.
  - If the FIFO is full, pending bits are held.
  - A new event on an input whose pending bit is already set is merged and increments descartados (saturating).
- FIFO: synchronous, one write and one pop per cycle allowed. Simultaneous write and pop when full is not possible, because writes are blocked while full. Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - OCIOSO: tx=1. If enable=1 and the FIFO is not empty, pop into the shift register, set tx=0, go to START (same edge).
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DADOS with tx=bit0.
  - DADOS: N_BITS bits LSB first, each CLKS_PER_BIT cycles. After the last bit, tx=1 and go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to OCIOSO.
  - OCIOSO occupies at least 1 cycle, so back-to-back frames have stop time of STOP_BITS*CLKS_PER_BIT+1 cycles.
- Latency: event sampled at edge k → pending at k → FIFO write at k+1 → pop, and tx falls, at edge k+2 (FIFO previously empty, FSM idle, enable=1).
- enable=0 only blocks the start of new frames. A frame in progress completes, and events keep queuing.
- tx is registered; no glitches.

Test Plan:
All scenarios use CLOCK_HZ=100, BAUD_RATE=10 (CLKS_PER_BIT=10), STOP_BITS=1, N_BITS=8.
- Single acertou pulse at edge k, enable=1 → tx low from k+2 for 10 cycles, then bits 1,0,0,0,0,0,1,0 (0x41 LSB first) at 10 cycles each, then stop high. busy=1 for 100 cycles.
- acertou, errou and bloqueado all rise in the same cycle → frames 0x41, 0x45, 0x42 in that order. Each start bit begins 1 cycle after the previous stop bit ends. descartados=0.
- enable=0; 5 separate acertou pulses → fifo_cheia=1 after 4 enqueued, 5th held pending; a 6th pulse → descartados=1. Then enable=1 → exactly 5 frames of 0x41; fifo_cheia clears after the first pop.
- reset=0 for 1 cycle during the DADOS bit 3 of a frame, with 2 entries queued and bloqueado held high through reset → tx=1, busy=0, db_estado=0 next cycle. No frames follow; descartados=0.
- enable dropped to 0 mid-DADOS with 1 entry queued → current frame finishes intact, tx stays 1. enable=1 → queued frame starts on the following edge.
- errou held high for 300 cycles → exactly one 0x45 frame. Release and re-raise → a second 0x45 frame.

Source files
------------

// File: rtl/transmissor_status.sv
// rtl/transmissor_status.sv - reports controller outcome events to the host as UART bytes
module transmissor_status #(
  parameter int         BAUD_RATE      = 9600,
  parameter int         CLOCK_HZ       = 50_000_000,
  parameter int         STOP_BITS      = 1,
  parameter int         N_BITS         = 8,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [7:0] CODE_ACERTOU   = 8'h41,
  parameter logic [7:0] CODE_ERROU     = 8'h45,
  parameter logic [7:0] CODE_BLOQUEADO = 8'h42
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       acertou,
  input  logic       errou,
  input  logic       bloqueado,
  output logic       tx,
  output logic       busy,
  output logic       fifo_cheia,
  output logic [3:0] descartados,
  output logic [2:0] db_estado
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CW           = $clog2(STOP_CLKS + 1);
  localparam int BW           = $clog2(N_BITS + 1);
  localparam int PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [N_BITS-1:0] COD_A = N_BITS'(CODE_ACERTOU);
  localparam logic [N_BITS-1:0] COD_E = N_BITS'(CODE_ERROU);
  localparam logic [N_BITS-1:0] COD_B = N_BITS'(CODE_BLOQUEADO);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(N_BITS - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    START  = 3'd1,
    DADOS  = 3'd2,
    STOP   = 3'd3
  } estado_t;

  // Bit order in the event vectors: 0 = acertou, 1 = errou, 2 = bloqueado
  logic [2:0] nivel;
  logic [2:0] anterior;
  logic [2:0] subida;
  logic [2:0] pendente;
  logic [2:0] concessao;
  logic [2:0] fundido;
  logic [4:0] soma_desc;

  logic [N_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       contagem;
  logic              cheio;
  logic              vazio;
  logic              escreve;
  logic              pop;
  logic [N_BITS-1:0] codigo;

  estado_t           estado;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [N_BITS-1:0] shreg;

  assign nivel   = {bloqueado, errou, acertou};
  assign subida  = nivel & ~anterior;
  assign cheio   = (contagem == CNT_FULL);
  assign vazio   = (contagem == '0);
  assign escreve = |concessao;
  assign pop     = (estado == OCIOSO) && enable && !vazio;

  assign fifo_cheia = cheio;
  assign db_estado  = estado;

  // Fixed-priority grant of one pending event per cycle while the FIFO has room
  always_comb begin
    concessao = 3'b000;
    codigo    = COD_A;
    if (!cheio) begin
      if (pendente[0]) begin
        concessao = 3'b001;
        codigo    = COD_A;
      end else if (pendente[1]) begin
        concessao = 3'b010;
        codigo    = COD_E;
      end else if (pendente[2]) begin
        concessao = 3'b100;
        codigo    = COD_B;
      end
    end
  end

  // A rise on an input whose event is still waiting is folded into it and counted as lost
  always_comb begin
    fundido   = subida & pendente & ~concessao;
    soma_desc = {1'b0, descartados} + 5'(fundido[0]) + 5'(fundido[1]) + 5'(fundido[2]);
  end

  // Edge detection, pending bits and lost-event counter; reset snapshots levels so held inputs stay quiet
  always_ff @(posedge clock) begin
    if (!reset) begin
      anterior    <= nivel;
      pendente    <= 3'b000;
      descartados <= 4'd0;
    end else begin
      anterior    <= nivel;
      pendente    <= (pendente & ~concessao) | subida;
      descartados <= (soma_desc > 5'd15) ? 4'd15 : soma_desc[3:0];
    end
  end

  // Event FIFO storage, no reset needed on the payload
  always_ff @(posedge clock) begin
    if (escreve) begin
      mem[wr_ptr] <= codigo;
    end
  end

  // Event FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      contagem <= '0;
    end else begin
      if (escreve) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      contagem <= contagem + (PW + 1)'(escreve) - (PW + 1)'(pop);
    end
  end

  // UART transmitter: start bit, LSB-first data, stop time, then at least one idle cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado   <= OCIOSO;
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            shreg  <= mem[rd_ptr];
            tx     <= 1'b0;
            busy   <= 1'b1;
            estado <= START;
          end
        end
        START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            estado   <= DADOS;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DADOS: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              tx     <= 1'b1;
              estado <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == STOP_LAST) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            estado   <= OCIOSO;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          estado   <= OCIOSO;
        end
      endcase
    end
  end

endmodule
